ece593w26_mac_stream: RTL and testbench
=======================================

// Module: ece593w26_mac_stream
// PURPOSE
//  Streaming, framed, pipelined multiply-accumulate. It is the successor to the fixed 8-bit free-running MAC.
//  It accepts (w,x) operand pairs over valid/ready and computes a dot product over a frame terminated by in_last.
//  It returns one accumulated result per frame over valid/ready.
//  Adds signed/unsigned mode, a parametrised accumulator width, optional saturation, overflow flag and element count.
//  Sits between the operand sequencer and the ALU result writeback.
// PARAMETERS
//  N      8        operand width (w, x)
//  ACC_W  2*N+8    accumulator/result width; must be >= 2*N
//  LEN_W  8        element counter width; max frame length 2**LEN_W-1
//  SAT    1        1: saturate accumulator at ACC_W bounds; 0: wrap modulo 2**ACC_W
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      operand pair valid
//  in_ready     out  1      block can accept operand pair
//  w            in   N      weight operand
//  x            in   N      data operand
//  in_last      in   1      qualifies final element of frame
//  signed_mode  in   1      1: two's-complement operands; sampled on first element of frame
//  out_valid    out  1      frame result valid
//  out_ready    in   1      downstream accepts result
//  f            out  ACC_W  accumulated result (signed or unsigned per frame mode)
//  out_ovf      out  1      frame overflowed ACC_W range (sticky within frame)
//  out_count    out  LEN_W  number of elements in frame
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; in_ready=1; out_valid=0; f=0; out_ovf=0; out_count=0; pipeline regs cleared.
//  Reset mid-frame discards the frame; no partial result is ever emitted.
//  Accept: an element is accepted only when in_valid && in_ready at the clk edge. in_valid is ignored otherwise.
//  Pipeline: S1 registers w,x,last. S2 registers 2N-bit product, sign/zero-extended per frame mode.
//    S3 adds the product into the ACC_W accumulator.
//  FSM states and transitions:
//   IDLE : in_ready=1. The first accepted element latches signed_mode, clears acc/ovf/count, and moves to RUN.
//          If that element has in_last set, the FSM moves straight to DRAIN.
//   RUN  : in_ready=1. Each accepted element increments count.
//          Move to DRAIN on the accepted element that has in_last set.
//          Also move to DRAIN on the accepted element that makes count == 2**LEN_W-1 (implicit last).
//   DRAIN: in_ready=0. Waits 2 cycles for S2/S3 to flush, then moves to HOLD.
//   HOLD : out_valid=1. f, out_ovf and out_count stay stable until out_valid && out_ready.
//          On that handshake: out_valid drops, the FSM moves to IDLE, and in_ready=1 from the next cycle.
//  Latency: last element accepted at edge T -> out_valid high after edge T+3 with out_ready irrelevant until then.
//  Throughput: 1 element/cycle inside a frame. One frame is in flight; the next frame starts after the result handoff.
//  Arithmetic: products are exact in 2N bits. Accumulation is checked for overflow against the ACC_W range.
//    Signed range: [-2**(ACC_W-1), 2**(ACC_W-1)-1]. Unsigned range: [0, 2**ACC_W-1].
//   SAT=1: on overflow, clamp to the bound in the direction of the overflow and set out_ovf.
//          Later elements continue from the clamped value.
//   SAT=0: wrap; out_ovf is still set on any overflow.
//  in_last is ignored while in_ready=0. signed_mode changes mid-frame have no effect.
//  out_ready while out_valid=0 is ignored. f holds the last result after handoff until a new frame completes.
// TESTING
//  1 Unsigned frame (2,3),(4,5),(255,255)+last -> f=65051, out_count=3, ovf=0, out_valid 3 cycles after last.
//  2 Signed frame (-1,-1),(-128,127)+last -> f=-16255 (sign-extended ACC_W), out_count=2.
//  3 ACC_W=16, SAT=1, unsigned (255,255)x2 -> f=16'hFFFF, out_ovf=1.
//    Same stimulus with SAT=0 -> f=16'hFC02, out_ovf=1.
//  4 Backpressure: hold out_ready=0 for 5 cycles in HOLD -> f/out_count stable, in_ready=0 throughout.
//    in_valid pulses during that time are not counted.
//  5 LEN_W=3, 7 elements (1,1) with no in_last -> implicit last, f=7, out_count=7.
//    An 8th element is accepted only after handoff and starts a new frame.
//  6 Drop rst_n mid-RUN after 2 elements, release, send single element (3,3)+last -> f=9, out_count=1.
//    No result is emitted for the aborted frame.

Source files
------------

// File: rtl/ece593w26_mac_stream.sv
// ece593w26_mac_stream
//   Framed, pipelined multiply-accumulate. The block accepts (w,x) operand pairs over valid/ready.
//   It accumulates their products over a frame that ends on in_last, or when the element counter fills.
//   It returns one result per frame over valid/ready.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready operand-pair handshake; w, x operands; in_last marks final element
//   signed_mode       two's-complement operands, sampled on the first element of a frame
//   out_valid/out_ready result handshake
//   f                 accumulated result (ACC_W bits)
//   out_ovf           accumulation left the ACC_W range during the frame
//   out_count         number of elements in the frame
module ece593w26_mac_stream #(
    parameter int N     = 8,
    parameter int ACC_W = 2*N+8,
    parameter int LEN_W = 8,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     w,
    input  logic [N-1:0]     x,
    input  logic             in_last,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] f,
    output logic             out_ovf,
    output logic [LEN_W-1:0] out_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

    localparam logic [LEN_W-1:0] CNT_MAX = '1;
    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);
    localparam logic [ACC_W-1:0] SMAX    = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN    = {1'b1, {(ACC_W-1){1'b0}}};

    state_t state, state_nxt;

    logic             accept;
    logic             frame_start;
    logic             frame_signed;
    logic [LEN_W-1:0] count, count_inc;
    logic [1:0]       drain_cnt;
    logic             drain_done;

    logic             s1_v;
    logic [N-1:0]     s1_w, s1_x;
    logic             s2_v;
    logic [ACC_W-1:0] s2_p;
    logic [ACC_W-1:0] acc;
    logic             acc_ovf;

    logic signed [2*N-1:0]   prod_s;
    logic        [2*N-1:0]   prod_u;
    logic        [ACC_W-1:0] prod_ext;
    logic        [ACC_W:0]   sum;
    logic                    ovf_now;
    logic        [ACC_W-1:0] sat_val;
    logic        [ACC_W-1:0] acc_nxt;

    // FSM: next state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept)
                    state_nxt = (in_last || CNT_ONE == CNT_MAX) ? DRAIN : RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                if (accept && (in_last || count_inc == CNT_MAX))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_done)
                    state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept      = in_valid && in_ready;
    assign frame_start = accept && (state == IDLE);
    assign count_inc   = count + CNT_ONE;
    // Last product reaches S2 one edge after acceptance and the accumulator one edge later.
    // The result registers load on the third edge, so the result is visible after edge T+3.
    assign drain_done  = (drain_cnt == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            drain_cnt    <= '0;
            count        <= '0;
            frame_signed <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (frame_start) begin
                frame_signed <= signed_mode;
                count        <= CNT_ONE;
            end else if (accept) begin
                count <= count_inc;
            end
        end
    end

    // Product stage: exact 2N-bit product, extended to ACC_W per frame mode
    always_comb begin
        prod_s = $signed({{N{s1_w[N-1]}}, s1_w}) * $signed({{N{s1_x[N-1]}}, s1_x});
        prod_u = {{N{1'b0}}, s1_w} * {{N{1'b0}}, s1_x};
        if (frame_signed)
            prod_ext = ACC_W'(prod_s);
        else
            prod_ext = ACC_W'(prod_u);
    end

    // Accumulate stage: one guard bit exposes overflow in either mode
    always_comb begin
        if (frame_signed) begin
            sum     = {acc[ACC_W-1], acc} + {s2_p[ACC_W-1], s2_p};
            ovf_now = sum[ACC_W] != sum[ACC_W-1];
            sat_val = sum[ACC_W] ? SMIN : SMAX;
        end else begin
            sum     = {1'b0, acc} + {1'b0, s2_p};
            ovf_now = sum[ACC_W];
            sat_val = '1;
        end
        acc_nxt = (SAT != 0 && ovf_now) ? sat_val : sum[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s1_w      <= '0;
            s1_x      <= '0;
            s2_v      <= 1'b0;
            s2_p      <= '0;
            acc       <= '0;
            acc_ovf   <= 1'b0;
            f         <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
        end else begin
            s1_v <= accept;
            if (accept) begin
                s1_w <= w;
                s1_x <= x;
            end
            s2_v <= s1_v;
            if (s1_v)
                s2_p <= prod_ext;
            // The previous frame has fully drained before a new one can start,
            // so clearing here never collides with an in-flight product.
            if (frame_start) begin
                acc     <= '0;
                acc_ovf <= 1'b0;
            end else if (s2_v) begin
                acc     <= acc_nxt;
                acc_ovf <= acc_ovf | ovf_now;
            end
            if (state == DRAIN && drain_done) begin
                f         <= acc;
                out_ovf   <= acc_ovf;
                out_count <= count;
            end
        end
    end

endmodule

// File: tb/tb_ece593w26_mac_stream.sv
// Bench for ece593w26_mac_stream: four parameterisations share operand inputs,
// each with its own valid/ready. Frames come from a table; expected results are
// queued when a frame is driven and compared when the DUT hands the result off.
module tb_ece593w26_mac_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_valid, out_ready;
    logic [3:0] in_ready, out_valid, ovf;
    logic [7:0] w, x;
    logic       last, mode;
    logic [23:0] f0, f3;
    logic [15:0] f1, f2;
    logic [7:0]  c0, c1, c2;
    logic [2:0]  c3;

    always #5 clk = ~clk;

    ece593w26_mac_stream u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .w(w), .x(x), .in_last(last), .signed_mode(mode), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .f(f0), .out_ovf(ovf[0]), .out_count(c0));
    ece593w26_mac_stream #(.ACC_W(16), .SAT(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .w(w), .x(x), .in_last(last), .signed_mode(mode), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .f(f1), .out_ovf(ovf[1]), .out_count(c1));
    ece593w26_mac_stream #(.ACC_W(16), .SAT(0)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .w(w), .x(x), .in_last(last), .signed_mode(mode), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .f(f2), .out_ovf(ovf[2]), .out_count(c2));
    ece593w26_mac_stream #(.LEN_W(3)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]),
        .in_ready(in_ready[3]), .w(w), .x(x), .in_last(last), .signed_mode(mode), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .f(f3), .out_ovf(ovf[3]), .out_count(c3));

    typedef struct {
        int              dut;
        bit              mode;
        int              n;
        bit              use_last;
        logic [0:7][7:0] w;
        logic [0:7][7:0] x;
        logic [31:0]     ef;
        logic            eovf;
        logic [31:0]     ecnt;
    } vec_t;

    typedef struct {
        logic [31:0] f;
        logic        ovf;
        logic [31:0] cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] fv(int d);
        case (d)
            0:       return {8'd0, f0};
            1:       return {16'd0, f1};
            2:       return {16'd0, f2};
            default: return {8'd0, f3};
        endcase
    endfunction

    function automatic logic [31:0] cv(int d);
        case (d)
            0:       return {24'd0, c0};
            1:       return {24'd0, c1};
            2:       return {24'd0, c2};
            default: return {29'd0, c3};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int d, input bit m, input int n, input bit ul, input logic [63:0] ww,
                       input logic [63:0] xx, input logic [31:0] ef, input logic eo, input int ec);
        vec_t v;
        v.dut = d; v.mode = m; v.n = n; v.use_last = ul; v.w = ww; v.x = xx;
        v.ef = ef; v.eovf = eo; v.ecnt = ec;
        tbl.push_back(v);
    endtask

    task automatic push_exp(input logic [31:0] ef, input logic eo, input logic [31:0] ec);
        exp_t e;
        e.f = ef; e.ovf = eo; e.cnt = ec;
        sb.push_back(e);
    endtask

    // Called #1 after an edge; returns #1 after the edge that accepted the element.
    task automatic send_elem(input int d, input logic [7:0] ww, input logic [7:0] xx, input bit l, input bit m);
        int k = 0;
        w = ww; x = xx; last = l; mode = m; in_valid[d] = 1'b1;
        while (!in_ready[d] && k < 50) begin
            @(posedge clk); #1; k++;
        end
        if (k >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid[d] = 1'b0; last = 1'b0;
    endtask

    // Waits (bounded) for the result, compares against the scoreboard, then hands it off.
    task automatic get_result(input int d, input int exp_lat);
        int   k = 0;
        exp_t e;
        while (!out_valid[d] && k < 50) begin
            @(posedge clk); #1; k++;
        end
        if (!out_valid[d]) begin
            chk("out_valid_timeout", 32'd0, 32'd1);
            return;
        end
        if (exp_lat >= 0) chk("latency", k, exp_lat);
        chk("in_ready_hold", {31'd0, in_ready[d]}, 32'd0);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("f", fv(d), e.f);
            chk("ovf", {31'd0, ovf[d]}, {31'd0, e.ovf});
            chk("count", cv(d), e.cnt);
        end
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        chk("out_valid_drop", {31'd0, out_valid[d]}, 32'd0);
        chk("in_ready_after", {31'd0, in_ready[d]}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        push_exp(v.ef, v.eovf, v.ecnt);
        for (int i = 0; i < v.n; i++)
            // mode is flipped after the first element: the frame must keep its sampled mode
            send_elem(v.dut, v.w[i], v.x[i], v.use_last && (i == v.n - 1), (i == 0) ? v.mode : ~v.mode);
        get_result(v.dut, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        add(0, 0, 3, 1, {8'd2, 8'd4, 8'd255, 40'd0}, {8'd3, 8'd5, 8'd255, 40'd0}, 32'd65051, 0, 3);
        add(0, 1, 2, 1, {8'hFF, 8'h80, 48'd0}, {8'hFF, 8'h7F, 48'd0}, 32'hFFC081, 0, 2);
        add(0, 1, 2, 1, {8'h80, 8'h80, 48'd0}, {8'h80, 8'h80, 48'd0}, 32'h008000, 0, 2);
        add(1, 0, 2, 1, {8'd255, 8'd255, 48'd0}, {8'd255, 8'd255, 48'd0}, 32'hFFFF, 1, 2);
        add(2, 0, 2, 1, {8'd255, 8'd255, 48'd0}, {8'd255, 8'd255, 48'd0}, 32'hFC02, 1, 2);
        add(2, 0, 2, 1, {8'd255, 8'd255, 48'd0}, {8'd255, 8'd2, 48'd0}, 32'hFFFF, 0, 2);
        add(1, 1, 3, 1, {8'h80, 8'h7F, 8'h7F, 40'd0}, {8'h80, 8'h7F, 8'h02, 40'd0}, 32'h7FFF, 0, 3);
        add(1, 1, 4, 1, {8'h80, 8'h80, 8'h80, 8'd1, 32'd0}, {8'h7F, 8'h7F, 8'h7F, 8'd1, 32'd0}, 32'h8001, 1, 4);
        add(2, 1, 4, 1, {8'h80, 8'h80, 8'h80, 8'd1, 32'd0}, {8'h7F, 8'h7F, 8'h7F, 8'd1, 32'd0}, 32'h4181, 1, 4);
        add(3, 0, 7, 0, {{7{8'd1}}, 8'd0}, {{7{8'd1}}, 8'd0}, 32'd7, 0, 7);

        rst_n = 1'b0; in_valid = '0; out_ready = '0; w = '0; x = '0; last = 1'b0; mode = 1'b0;
        #12;
        for (int d = 0; d < 4; d++) begin
            chk("rst_out_valid", {31'd0, out_valid[d]}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready[d]}, 32'd1);
            chk("rst_f", fv(d), 32'd0);
            chk("rst_ovf", {31'd0, ovf[d]}, 32'd0);
            chk("rst_count", cv(d), 32'd0);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) run_vec(tbl[i]);

        // Backpressure: result held, in_ready low, in_valid pulses not counted
        push_exp(32'd14, 0, 2);
        send_elem(0, 8'd1, 8'd2, 0, 0);
        send_elem(0, 8'd3, 8'd4, 1, 0);
        for (int i = 0; i < 8; i++) begin
            in_valid[0] = i[0];
            @(posedge clk); #1;
            chk("bp_in_ready", {31'd0, in_ready[0]}, 32'd0);
            if (i >= 2) begin
                chk("bp_out_valid", {31'd0, out_valid[0]}, 32'd1);
                chk("bp_f", fv(0), 32'd14);
                chk("bp_count", cv(0), 32'd2);
            end
        end
        in_valid[0] = 1'b0;
        get_result(0, -1);
        push_exp(32'd25, 0, 1);
        send_elem(0, 8'd5, 8'd5, 1, 0);
        get_result(0, 3);

        // Implicit last at 7 elements; an 8th waiting element only starts the next frame
        push_exp(32'd7, 0, 7);
        for (int i = 0; i < 7; i++) send_elem(3, 8'd1, 8'd1, 0, 0);
        w = 8'd2; x = 8'd3; last = 1'b1; in_valid[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("il_in_ready", {31'd0, in_ready[3]}, 32'd0);
        end
        get_result(3, -1);
        push_exp(32'd6, 0, 1);
        @(posedge clk); #1;
        in_valid[3] = 1'b0; last = 1'b0;
        get_result(3, 3);

        // Reset mid-frame: aborted frame yields nothing
        send_elem(0, 8'd7, 8'd7, 0, 0);
        send_elem(0, 8'd9, 8'd9, 0, 0);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_f", fv(0), 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready[0]}, 32'd1);
        @(posedge clk); #1; rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_no_out", {31'd0, out_valid[0]}, 32'd0);
        end
        push_exp(32'd9, 0, 1);
        send_elem(0, 8'd3, 8'd3, 1, 0);
        get_result(0, 3);

        // Random frames on the default instance, checked against an integer model
        for (int r = 0; r < 6; r++) begin
            int              n;
            bit              m;
            longint          sum;
            logic [0:7][7:0] rw, rx;
            int              sw, sx;
            n = $urandom_range(1, 8);
            m = $urandom_range(0, 1);
            sum = 0;
            for (int i = 0; i < n; i++) begin
                rw[i] = $urandom_range(0, 255);
                rx[i] = $urandom_range(0, 255);
                if (m) begin
                    sw = $signed(rw[i]); sx = $signed(rx[i]);
                end else begin
                    sw = int'(rw[i]); sx = int'(rx[i]);
                end
                sum += longint'(sw) * longint'(sx);
            end
            push_exp({8'd0, sum[23:0]}, 0, n);
            for (int i = 0; i < n; i++) send_elem(0, rw[i], rx[i], i == n - 1, (i == 0) ? m : ~m);
            get_result(0, 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
